// File: rtl/pmsm_commutation_ctrl.sv
// Six-step PMSM commutation controller: IDLE/ALIGN/RUN/FAULT sequencing, edge-aligned PWM
// gating of the phase pattern, and dead time on every sector change. All outputs are registered.
module pmsm_commutation_ctrl #(
   parameter int POS_W        = 16,
   parameter int PWM_W        = 8,
   parameter int ALIGN_CYCLES = 1000,
   parameter int ALIGN_DUTY   = 64,
   parameter int DEAD_CYCLES  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             direction,
   input  logic [PWM_W-1:0] duty,
   input  logic [POS_W-1:0] position,
   input  logic             overcurrent,
   input  logic             fault_clr,
   output logic [2:0]       V_phase,
   output logic [2:0]       sector,
   output logic [1:0]       state,
   output logic             fault
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ALIGN = 2'b01,
      ST_RUN   = 2'b10,
      ST_FAULT = 2'b11
   } state_t;

   localparam int AW = (ALIGN_CYCLES > 1) ? $clog2(ALIGN_CYCLES) : 1;
   localparam int DW = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;

   localparam logic [AW-1:0]    ALIGN_LAST   = AW'(ALIGN_CYCLES - 1);
   localparam logic [DW-1:0]    DEAD_LOAD    = DW'(DEAD_CYCLES);
   localparam logic [PWM_W-1:0] PWM_MAX      = '1;
   localparam logic [PWM_W-1:0] ALIGN_DUTY_V = PWM_W'(ALIGN_DUTY);

   function automatic logic [2:0] phase_pattern(input logic [2:0] s);
      logic [2:0] p;
      case (s)
         3'd0:    p = 3'b001;
         3'd1:    p = 3'b011;
         3'd2:    p = 3'b010;
         3'd3:    p = 3'b110;
         3'd4:    p = 3'b100;
         3'd5:    p = 3'b101;
         default: p = 3'b000;
      endcase
      return p;
   endfunction

   state_t           state_q, state_d;
   logic [AW-1:0]    align_q, align_d;
   logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [PWM_W-1:0] duty_q, duty_d;
   logic [2:0]       sector_q, sector_d;
   logic [DW-1:0]    dead_q, dead_d;
   logic [2:0]       vphase_q, vphase_d;
   logic             fault_q, fault_d;

   // position*6 fits in POS_W+3 bits; the top three bits are the raw sector 0..5
   logic [POS_W+2:0] prod;
   logic [2:0]       s_raw;
   logic [2:0]       s_eff;
   logic             pwm_on_d;
   logic             drive_d;

   assign prod  = {3'b000, position} * (POS_W+3)'(6);
   assign s_raw = 3'(prod >> POS_W);
   assign s_eff = !direction ? s_raw
                : (s_raw >= 3'd3) ? (s_raw - 3'd3) : (s_raw + 3'd3);

   always_comb begin
      state_d = state_q;
      align_d = align_q;
      if (overcurrent) begin
         state_d = ST_FAULT;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (enable) begin
                  state_d = ST_ALIGN;
                  align_d = '0;
               end
            end
            ST_ALIGN: begin
               align_d = align_q + 1'b1;
               if (!enable)                  state_d = ST_IDLE;
               else if (align_q == ALIGN_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
               if (!enable) state_d = ST_IDLE;
            end
            ST_FAULT: begin
               if (fault_clr && !enable) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Outside RUN the latch follows ALIGN_DUTY so alignment drives from its first clock.
   always_comb begin
      pwm_cnt_d = pwm_cnt_q + 1'b1;
      duty_d    = duty_q;
      if (pwm_cnt_q == PWM_MAX)
         duty_d = (state_q == ST_RUN) ? duty : ALIGN_DUTY_V;
      pwm_on_d  = (pwm_cnt_d < duty_d);
   end

   always_comb begin
      sector_d = (state_d == ST_RUN) ? s_eff : 3'd0;
      if (sector_d != sector_q)
         dead_d = DEAD_LOAD;
      else if (dead_q != '0)
         dead_d = dead_q - 1'b1;
      else
         dead_d = '0;
      drive_d  = ((state_d == ST_ALIGN) || (state_d == ST_RUN)) && pwm_on_d && (dead_d == '0);
      vphase_d = drive_d ? phase_pattern(sector_d) : 3'b000;
      fault_d  = (state_d == ST_FAULT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         align_q   <= '0;
         pwm_cnt_q <= '0;
         duty_q    <= '0;
         sector_q  <= 3'd0;
         dead_q    <= '0;
         vphase_q  <= 3'b000;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         align_q   <= align_d;
         pwm_cnt_q <= pwm_cnt_d;
         duty_q    <= duty_d;
         sector_q  <= sector_d;
         dead_q    <= dead_d;
         vphase_q  <= vphase_d;
         fault_q   <= fault_d;
      end
   end

   assign V_phase = vphase_q;
   assign sector  = sector_q;
   assign state   = state_q;
   assign fault   = fault_q;

endmodule

// File: tb/tb_pmsm_commutation_ctrl.sv
// Directed plus randomized bench for pmsm_commutation_ctrl against a cycle-level behavioural model.
module tb_pmsm_commutation_ctrl;
   localparam int POS_W        = 16;
   localparam int PWM_W        = 8;
   localparam int ALIGN_CYCLES = 8;
   localparam int ALIGN_DUTY   = 64;
   localparam int DEAD_CYCLES  = 4;
   localparam int PWM_PERIOD   = 256;

   localparam int S_IDLE  = 0;
   localparam int S_ALIGN = 1;
   localparam int S_RUN   = 2;
   localparam int S_FAULT = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        direction = 1'b0;
   logic [7:0]  duty = 8'd0;
   logic [15:0] position = 16'd0;
   logic        overcurrent = 1'b0;
   logic        fault_clr = 1'b0;
   logic [2:0]  V_phase;
   logic [2:0]  sector;
   logic [1:0]  state;
   logic        fault;

   int n_err = 0;
   int n_checks = 0;

   // behavioural model state
   int m_cnt, m_ld, m_st, m_al, m_sec, m_dead, m_v;
   int pattern [6] = '{1, 3, 2, 6, 4, 5};

   pmsm_commutation_ctrl #(
      .POS_W(POS_W), .PWM_W(PWM_W), .ALIGN_CYCLES(ALIGN_CYCLES),
      .ALIGN_DUTY(ALIGN_DUTY), .DEAD_CYCLES(DEAD_CYCLES)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .direction(direction),
      .duty(duty), .position(position), .overcurrent(overcurrent),
      .fault_clr(fault_clr), .V_phase(V_phase), .sector(sector),
      .state(state), .fault(fault)
   );

   always #5 clk = ~clk;

   function automatic int sector_of(input int pos, input logic dir);
      int raw;
      raw = (pos * 6) / 65536;
      return dir ? (raw + 3) % 6 : raw;
   endfunction

   task automatic model_reset();
      m_cnt = 0; m_ld = 0; m_st = S_IDLE; m_al = 0;
      m_sec = 0; m_dead = 0; m_v = 0;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic check_all();
      chk("V_phase", 32'(V_phase), m_v);
      chk("sector", 32'(sector), m_sec);
      chk("state", 32'(state), m_st);
      chk("fault", 32'(fault), (m_st == S_FAULT) ? 1 : 0);
   endtask

   task automatic tick();
      int n_cnt, n_ld, n_st, n_al, n_sec, n_dead;
      n_cnt = (m_cnt + 1) % PWM_PERIOD;
      n_ld  = m_ld;
      if (m_cnt == PWM_PERIOD - 1) n_ld = (m_st == S_RUN) ? int'(duty) : ALIGN_DUTY;
      n_st = m_st;
      n_al = m_al;
      if (overcurrent) n_st = S_FAULT;
      else if (m_st == S_IDLE) begin
         if (enable) begin n_st = S_ALIGN; n_al = 0; end
      end else if (m_st == S_ALIGN) begin
         n_al = m_al + 1;
         if (!enable) n_st = S_IDLE;
         else if (m_al == ALIGN_CYCLES - 1) n_st = S_RUN;
      end else if (m_st == S_RUN) begin
         if (!enable) n_st = S_IDLE;
      end else begin
         if (fault_clr && !enable) n_st = S_IDLE;
      end
      n_sec  = (n_st == S_RUN) ? sector_of(int'(position), direction) : 0;
      n_dead = (n_sec != m_sec) ? DEAD_CYCLES : ((m_dead > 0) ? m_dead - 1 : 0);
      @(posedge clk);
      m_cnt = n_cnt; m_ld = n_ld; m_st = n_st; m_al = n_al;
      m_sec = n_sec; m_dead = n_dead;
      m_v = ((n_st == S_ALIGN || n_st == S_RUN) && n_cnt < n_ld && n_dead == 0) ? pattern[n_sec] : 0;
      #1;
      check_all();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int n_al_cyc;
      int on_cnt;
      int guard;

      model_reset();
      #23;
      check_all();
      rst_n = 1'b1;

      // let the PWM latch pick up ALIGN_DUTY, then enter ALIGN just before a wrap
      ticks(300);
      for (int i = 0; i < PWM_PERIOD && m_cnt != 250; i++) tick();
      enable = 1'b1;
      duty = 8'd128;
      tick();
      n_al_cyc = 0;
      while (state === 2'b01 && n_al_cyc < 20) begin
         n_al_cyc++;
         tick();
      end
      chk("align_len", n_al_cyc, ALIGN_CYCLES);
      chk("run_after_align", 32'(state), S_RUN);

      // position sweep, forward, 50% duty
      for (int k = 0; k <= 16; k++) begin
         position = (k == 16) ? 16'hFFFF : 16'(k * 16'h1000);
         ticks(60);
      end

      // direction toggle at 0x3000: sector 1 -> 4 with dead time
      duty = 8'd255;
      position = 16'h3000;
      ticks(20);
      chk("fwd_sector", 32'(sector), 1);
      direction = 1'b1;
      tick();
      chk("rev_sector", 32'(sector), 4);
      for (int i = 0; i < DEAD_CYCLES; i++) begin
         chk("dead_off", 32'(V_phase), 0);
         if (i < DEAD_CYCLES - 1) tick();
      end
      ticks(20);

      // duty change mid period takes effect only after the wrap
      duty = 8'd32;
      ticks(300);
      for (int i = 0; i < PWM_PERIOD && m_cnt != 100; i++) tick();
      duty = 8'd200;
      on_cnt = 0;
      guard = 0;
      while (m_cnt != PWM_PERIOD - 1 && guard < PWM_PERIOD) begin
         tick();
         guard++;
         if (V_phase !== 3'b000) on_cnt++;
      end
      chk("old_duty_tail_on", on_cnt, 0);
      on_cnt = 0;
      for (int i = 0; i < PWM_PERIOD; i++) begin
         tick();
         if (V_phase !== 3'b000) on_cnt++;
      end
      chk("new_duty_on", on_cnt, 200);
      duty = 8'd0;
      on_cnt = 0;
      for (int i = 0; i < PWM_PERIOD; i++) begin
         tick();
         if (V_phase !== 3'b000) on_cnt++;
      end
      chk("zero_duty_on", on_cnt, 0);

      // fault entry and exit rules
      duty = 8'd128;
      ticks(10);
      overcurrent = 1'b1;
      tick();
      overcurrent = 1'b0;
      chk("fault_state", 32'(state), S_FAULT);
      chk("fault_flag", 32'(fault), 1);
      chk("fault_vphase", 32'(V_phase), 0);
      fault_clr = 1'b1;
      ticks(5);
      chk("fault_hold_en", 32'(state), S_FAULT);
      enable = 1'b0;
      tick();
      chk("fault_exit", 32'(state), S_IDLE);
      fault_clr = 1'b0;

      // randomized operation
      enable = 1'b1;
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 49) == 0) enable = ~enable;
         if ($urandom_range(0, 199) == 0) direction = ~direction;
         if ($urandom_range(0, 99) == 0) duty = 8'($urandom);
         position = position + 16'($urandom_range(0, 800));
         overcurrent = ($urandom_range(0, 299) == 0);
         fault_clr = ($urandom_range(0, 3) == 0);
         tick();
      end
      overcurrent = 1'b0;
      fault_clr = 1'b0;

      // asynchronous reset mid-RUN while driving 011
      enable = 1'b0;
      fault_clr = 1'b1;
      ticks(2);
      fault_clr = 1'b0;
      enable = 1'b1;
      direction = 1'b0;
      position = 16'h3000;
      duty = 8'd200;
      guard = 0;
      while (!(state === 2'b10 && V_phase === 3'b011) && guard < 2000) begin
         tick();
         guard++;
      end
      chk("reach_011", 32'(V_phase), 3);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all();
      @(posedge clk);
      #1;
      check_all();
      rst_n = 1'b1;
      enable = 1'b0;
      ticks(5);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
